// File: rtl/tile_wb_pkg.sv
// rtl/tile_wb_pkg.sv - shared types and constants for the tile Wishbone responder
package tile_wb_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Index width for a bank of n registers; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tile_wb_regfile.sv
// rtl/tile_wb_regfile.sv - register bank with byte-lane writes, read-only slot 0
module tile_wb_regfile
  import tile_wb_pkg::*;
#(
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] TILE_ID  = 32'h0000_0000,
  localparam int         IW       = idx_w(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [IW-1:0]            i_wr_idx,
  input  logic [WB_SELW-1:0]       i_wr_sel,
  input  logic [WB_DW-1:0]         i_wr_data,
  input  logic [IW-1:0]            i_rd_idx,
  output logic [WB_DW-1:0]         o_rd_data,
  output logic [NUM_REGS*WB_DW-1:0] o_regs
);

  logic [WB_DW-1:0] w_bank [NUM_REGS];

  assign w_bank[0] = TILE_ID;

  // Slot 0 has no storage; writes addressed to it fall through every compare.
  for (genvar k = 1; k < NUM_REGS; k++) begin : gen_reg
    logic [WB_DW-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_q <= '0;
      end else if (i_wr_en && (i_wr_idx == IW'(k))) begin
        for (int b = 0; b < WB_SELW; b++) begin
          if (i_wr_sel[b]) r_q[8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
    end

    assign w_bank[k] = r_q;
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : gen_flat
    assign o_regs[WB_DW*k +: WB_DW] = w_bank[k];
  end

  assign o_rd_data = w_bank[i_rd_idx];

endmodule

// File: rtl/tile_wb_responder.sv
// rtl/tile_wb_responder.sv - Wishbone classic slave: window decode, wait states, one-cycle ack
module tile_wb_responder
  import tile_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FF00,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] TILE_ID     = 32'h0000_0000
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [WB_SELW-1:0]        wbs_sel_i,
  input  logic [WB_DW-1:0]          wbs_dat_i,
  input  logic [31:0]               wbs_adr_i,
  output logic                      wbs_ack_o,
  output logic [WB_DW-1:0]          wbs_dat_o,
  output logic [NUM_REGS*WB_DW-1:0] regs_o,
  output logic                      busy_o
);

  localparam int         IW       = idx_w(NUM_REGS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t              r_state, w_next;
  logic [3:0]          r_cnt, w_cnt_next;
  logic                r_we;
  logic [WB_SELW-1:0]  r_sel;
  logic [WB_DW-1:0]    r_dat;
  logic [IW-1:0]       r_idx;
  logic                r_ack;
  logic [WB_DW-1:0]    r_dat_o;

  logic                w_hit, w_req, w_latch, w_enter_ack;
  logic                w_t_we;
  logic [WB_SELW-1:0]  w_t_sel;
  logic [WB_DW-1:0]    w_t_dat;
  logic [IW-1:0]       w_t_idx;
  logic [WB_DW-1:0]    w_rd_data;

  assign w_hit = ((wbs_adr_i ^ BASE_ADDR) & ADDR_MASK) == 32'h0;
  assign w_req = wbs_cyc_i & wbs_stb_i & w_hit;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_latch    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_latch = 1'b1;
          if (WAIT_STATES == 0) begin
            w_next = ST_ACK;
          end else begin
            w_next     = ST_WAIT;
            w_cnt_next = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!(wbs_cyc_i && wbs_stb_i)) w_next = ST_IDLE;
        else if (r_cnt == 4'd0)        w_next = ST_ACK;
        else                           w_cnt_next = r_cnt - 4'd1;
      end
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // With zero wait states ACK is entered straight from IDLE, before the latch exists.
  assign w_enter_ack = (w_next == ST_ACK);
  assign w_t_we  = (r_state == ST_IDLE) ? wbs_we_i           : r_we;
  assign w_t_sel = (r_state == ST_IDLE) ? wbs_sel_i          : r_sel;
  assign w_t_dat = (r_state == ST_IDLE) ? wbs_dat_i          : r_dat;
  assign w_t_idx = (r_state == ST_IDLE) ? wbs_adr_i[IW+1:2]  : r_idx;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_dat   <= '0;
      r_idx   <= '0;
      r_ack   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) begin
        r_we  <= wbs_we_i;
        r_sel <= wbs_sel_i;
        r_dat <= wbs_dat_i;
        r_idx <= wbs_adr_i[IW+1:2];
      end
      r_ack   <= w_enter_ack;
      r_dat_o <= (w_enter_ack && !w_t_we) ? w_rd_data : '0;
    end
  end

  tile_wb_regfile #(
    .NUM_REGS (NUM_REGS),
    .TILE_ID  (TILE_ID)
  ) u_regfile (
    .i_clk     (wb_clk_i),
    .i_rst_n   (wb_rst_i),
    .i_wr_en   (w_enter_ack & w_t_we),
    .i_wr_idx  (w_t_idx),
    .i_wr_sel  (w_t_sel),
    .i_wr_data (w_t_dat),
    .i_rd_idx  (w_t_idx),
    .o_rd_data (w_rd_data),
    .o_regs    (regs_o)
  );

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat_o;
  assign busy_o    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tile_wb_responder.sv
// tb/tb_tile_wb_responder.sv - directed self-checking bench for tile_wb_responder
module tb_tile_wb_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, we = 1'b0;
  logic        stb1 = 1'b0, stb3 = 1'b0, stb0 = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat = 32'h0, adr = 32'h0;

  logic        ack1, ack3, ack0, busy1, busy3, busy0;
  logic [31:0] dato1, dato3, dato0;
  logic [255:0] regs1, regs3, regs0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tile_wb_responder #(.WAIT_STATES(1), .TILE_ID(32'hA5A5_0001)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wbs_stb_i(stb1), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr),
    .wbs_ack_o(ack1), .wbs_dat_o(dato1), .regs_o(regs1), .busy_o(busy1));

  tile_wb_responder #(.WAIT_STATES(3), .TILE_ID(32'h0000_0003)) u_dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wbs_stb_i(stb3), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr),
    .wbs_ack_o(ack3), .wbs_dat_o(dato3), .regs_o(regs3), .busy_o(busy3));

  tile_wb_responder #(.WAIT_STATES(0), .TILE_ID(32'h0000_0000)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wbs_stb_i(stb0), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr),
    .wbs_ack_o(ack0), .wbs_dat_o(dato0), .regs_o(regs0), .busy_o(busy0));

  function automatic logic cur_ack(input int which);
    case (which)
      1:       return ack1;
      3:       return ack3;
      default: return ack0;
    endcase
  endfunction

  function automatic logic [31:0] cur_dat(input int which);
    case (which)
      1:       return dato1;
      3:       return dato3;
      default: return dato0;
    endcase
  endfunction

  task automatic drive(input int which, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    cyc = 1'b1; we = w; adr = a; sel = s; dat = d;
    stb1 = (which == 1); stb3 = (which == 3); stb0 = (which == 0);
  endtask

  task automatic release_bus();
    cyc = 1'b0; stb1 = 1'b0; stb3 = 1'b0; stb0 = 1'b0; we = 1'b0;
  endtask

  // Runs one transfer from posedge+1; lat counts edges from drive to ack (-1 on timeout).
  task automatic xfer(input int which, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] rdata, output int lat, output logic ack_after);
    drive(which, w, a, s, d);
    lat = -1;
    rdata = 32'h0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (cur_ack(which)) begin
        lat = i;
        rdata = cur_dat(which);
        break;
      end
    end
    release_bus();
    @(posedge clk); #1;
    ack_after = cur_ack(which);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", ack1); end
    n_cmp++; if (dato1 !== 32'h0) begin n_err++; $display("FAIL reset_dat: got %h want 0", dato1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy1); end
    n_cmp++; if (regs1[31:0] !== 32'hA5A5_0001) begin n_err++; $display("FAIL reset_reg0: got %h want a5a50001", regs1[31:0]); end
    n_cmp++; if (regs1[255:32] !== 224'h0) begin n_err++; $display("FAIL reset_rw_regs: got %h want 0", regs1[255:32]); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_id();
    logic [31:0] rd; int lat; logic aa;
    xfer(1, 1'b0, 32'h3000_0000, 4'hF, 32'h0, rd, lat, aa);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL read_id_latency: got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'hA5A5_0001) begin n_err++; $display("FAIL read_id_data: got %h want a5a50001", rd); end
    n_cmp++; if (aa !== 1'b0) begin n_err++; $display("FAIL read_id_ack_width: ack still %b after one cycle", aa); end
    n_cmp++; if (dato1 !== 32'h0) begin n_err++; $display("FAIL read_id_dat_clear: got %h want 0", dato1); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int lat; logic aa;
    xfer(1, 1'b1, 32'h3000_0004, 4'b1111, 32'hDEAD_BEEF, rd, lat, aa);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL write_full_latency: got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL write_dat_o: got %h want 0", rd); end
    xfer(1, 1'b1, 32'h3000_0004, 4'b0010, 32'h0000_1200, rd, lat, aa);
    xfer(1, 1'b0, 32'h3000_0004, 4'hF, 32'h0, rd, lat, aa);
    n_cmp++; if (rd !== 32'hDEAD_12EF) begin n_err++; $display("FAIL lane_read: got %h want dead12ef", rd); end
    n_cmp++; if (regs1[63:32] !== 32'hDEAD_12EF) begin n_err++; $display("FAIL lane_regs_o: got %h want dead12ef", regs1[63:32]); end
  endtask

  task automatic test_ro_reg0();
    logic [31:0] rd; int lat; logic aa;
    xfer(1, 1'b1, 32'h3000_0000, 4'hF, 32'hFFFF_FFFF, rd, lat, aa);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL ro_write_ack: latency %0d want 2", lat); end
    xfer(1, 1'b0, 32'h3000_0000, 4'hF, 32'h0, rd, lat, aa);
    n_cmp++; if (rd !== 32'hA5A5_0001) begin n_err++; $display("FAIL ro_read: got %h want a5a50001", rd); end
    n_cmp++; if (regs1[31:0] !== 32'hA5A5_0001) begin n_err++; $display("FAIL ro_regs_o: got %h want a5a50001", regs1[31:0]); end
  endtask

  task automatic test_miss();
    int bad = 0;
    drive(1, 1'b0, 32'h3000_0100, 4'hF, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack1 !== 1'b0 || busy1 !== 1'b0) bad++;
    end
    release_bus();
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL miss_quiet: %0d cycles with ack/busy high, want 0", bad); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; int lat; logic aa; int acks = 0;
    drive(3, 1'b1, 32'h3000_0008, 4'hF, 32'h1234_5678);
    @(posedge clk); #1;
    n_cmp++; if (busy3 !== 1'b1) begin n_err++; $display("FAIL abort_busy_wait: got %b want 1", busy3); end
    @(posedge clk); #1;
    release_bus();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack3 === 1'b1) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
    n_cmp++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL abort_idle: busy %b want 0", busy3); end
    n_cmp++; if (regs3[95:64] !== 32'h0) begin n_err++; $display("FAIL abort_no_write: got %h want 0", regs3[95:64]); end
    xfer(3, 1'b1, 32'h3000_0008, 4'hF, 32'h1234_5678, rd, lat, aa);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL retry_latency: got %0d want 4", lat); end
    n_cmp++; if (regs3[95:64] !== 32'h1234_5678) begin n_err++; $display("FAIL retry_write: got %h want 12345678", regs3[95:64]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int lat; logic aa;
    logic [5:0] pattern = 6'b0;
    int bad_data = 0;
    xfer(0, 1'b1, 32'h3000_0004, 4'hF, 32'hCAFE_0001, rd, lat, aa);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL ws0_latency: got %0d want 1", lat); end
    drive(0, 1'b0, 32'h3000_0004, 4'hF, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pattern[i] = ack0;
      if (ack0 === 1'b1 && dato0 !== 32'hCAFE_0001) bad_data++;
    end
    release_bus();
    @(posedge clk); #1;
    n_cmp++; if (pattern !== 6'b010101) begin n_err++; $display("FAIL b2b_ack_pattern: got %b want 010101", pattern); end
    n_cmp++; if (bad_data !== 0) begin n_err++; $display("FAIL b2b_data: %0d acks with wrong data, want cafe0001", bad_data); end
  endtask

  task automatic test_reset_mid();
    drive(1, 1'b1, 32'h3000_000C, 4'hF, 32'h1111_2222);
    @(posedge clk); #1;
    n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b want 1", busy1); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL mid_reset_ack: got %b want 0", ack1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b want 0", busy1); end
    release_bus();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (regs1[127:96] !== 32'h0) begin n_err++; $display("FAIL mid_no_write: got %h want 0", regs1[127:96]); end
    n_cmp++; if (regs1[63:32] !== 32'h0) begin n_err++; $display("FAIL mid_reg1_cleared: got %h want 0", regs1[63:32]); end
    n_cmp++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL mid_ack_after: got %b want 0", ack1); end
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_byte_lanes();
    test_ro_reg0();
    test_miss();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tile_wb_responder.md
Name: tile_wb_responder

Overview:
- Wishbone classic-cycle slave instantiated inside each compute tile.
- Terminates the per-tile request bundle (stb/cyc/we/sel/dat/adr) that the fabric fans out, and returns ack and read data for the fabric's ack/data selection.
- Decodes its own address window, holds a small 32-bit register bank with byte-lane writes, and inserts a configurable number of wait states before a single-cycle ack.

Parameters:
- BASE_ADDR, 32'h3000_0000, tile window base address.
- ADDR_MASK, 32'hFFFF_FF00, mask bits that must match BASE_ADDR for a hit.
- NUM_REGS, 8, number of 32-bit registers (power of two, 2..64).
- WAIT_STATES, 1, cycles inserted between request acceptance and ack (0..15).
- TILE_ID, 32'h0000_0000, read-only value of register 0.

Ports:
- wb_clk_i  in  1  single clock, rising edge.
- wb_rst_i  in  1  asynchronous, active-low reset (0 = reset).
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_sel_i  in  4  byte-lane enables; bit n covers dat[8n+7:8n].
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  transfer acknowledge, registered.
- wbs_dat_o  out  32  read data, registered; valid only while ack is high.
- regs_o  out  NUM_REGS*32  flattened register bank; reg k at [32k+31:32k].
- busy_o  out  1  high in WAIT or ACK.

Behaviour:
- Reset (wb_rst_i low, async):
  - FSM to IDLE; wbs_ack_o=0, wbs_dat_o=0, busy_o=0.
  - All RW registers 0; regs_o slice 0 = TILE_ID always.
- hit = ((wbs_adr_i ^ BASE_ADDR) & ADDR_MASK) == 0.
- req = wbs_cyc_i & wbs_stb_i & hit.
- idx = wbs_adr_i[log2(NUM_REGS)+1:2]; adr[1:0] ignored.
- Registers: 0 is read-only (TILE_ID); 1..NUM_REGS-1 are RW.
- idx is always < NUM_REGS, so all in-window addresses alias onto the bank.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on req, latch we/sel/dat/idx. Go to WAIT with cnt=WAIT_STATES-1, or directly to ACK if WAIT_STATES=0.
  - WAIT: if cyc or stb is low, abort to IDLE (no write, no ack). Else if cnt==0, go to ACK; else cnt--.
  - On the edge entering ACK:
    - Write: perform masked write of latched data into latched idx, only for lanes with sel=1. Writes to idx 0 are ignored.
    - Read: load wbs_dat_o with reg[idx] (pre-write value irrelevant; reads do not write).
  - ACK: wbs_ack_o=1 for exactly one cycle, then IDLE unconditionally. wbs_dat_o returns to 0 on leaving ACK.
- Latency: ack is high in the (WAIT_STATES+1)th cycle after the cycle req is first sampled high.
  - Example: WAIT_STATES=1, req at edge N, ack high from edge N+2 to N+3.
- Back-to-back: stb held high after ack starts a new transfer from IDLE. Minimum 1 IDLE cycle between acks, so throughput is one transfer per WAIT_STATES+2 cycles.
- Non-hit requests: no state change, ack never asserted.
- Inputs changing during WAIT are ignored (latched values are used), except the cyc/stb abort.
- Reset asserted mid-transfer: immediate return to reset state; no partial write committed.
- regs_o reflects register contents combinationally from flops; an update is visible the cycle after the ACK entry edge.

Decomposition:
- Package tile_wb_pkg holds:
  - state encoding (IDLE=2'd0, WAIT=2'd1, ACK=2'd2);
  - WB_DW=32, WB_SELW=4;
  - the register-index width function.
- Sub-module tile_wb_regfile: NUM_REGS×32 bank with byte-lane write enable, read-only slot 0 = TILE_ID, async read, flattened output.
- The FSM and address decode stay in the top.

Test Plan:
- Reset then read idx 0 (adr 0x3000_0000, WAIT_STATES=1, TILE_ID=0xA5A5_0001) -> ack 2 cycles after req, dat_o=0xA5A5_0001, ack width 1 cycle.
- Write 0xDEAD_BEEF sel=4'b1111 to 0x3000_0004, then write 0x0000_1200 sel=4'b0010 to the same address, then read -> dat_o=0xDEAD_12EF; regs_o[63:32]=0xDEAD_12EF.
- Write 0xFFFF_FFFF to 0x3000_0000 -> ack returned, register 0 still reads TILE_ID.
- Request to 0x3000_0100 (outside window), stb held 10 cycles -> ack stays 0, busy_o stays 0.
- WAIT_STATES=3: write to 0x3000_0008, drop stb in the 2nd WAIT cycle -> no ack, reg 2 unchanged (0); a retry completes with ack 4 cycles after req.
- stb/cyc held high for 3 consecutive reads with WAIT_STATES=0 -> acks on cycles 1, 3, 5 after first req; wb_rst_i pulsed low mid-WAIT on a write -> ack=0 immediately, target register 0.
